// File: rtl/program_register_pkg.sv
// Shared definitions for the program register stack: opcode width and encodings.
package program_register_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_INCR  = 3'd2,
        OP_ADD   = 3'd3,
        OP_PUSH  = 3'd4,
        OP_POP   = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

endpackage

// File: rtl/program_register_stack_shadow_lifo.sv
// DEPTH x WIDTH LIFO used to save and restore the main register.
// The parent never issues a push when full or a pop when empty.
module shadow_lifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    rd_cnt;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    // Read index is clamped at zero so an empty stack never indexes out of range.
    assign rd_cnt = (count_q == '0) ? '0 : count_q - CW'(1);
    assign rd_idx = IW'(rd_cnt);
    assign wr_idx = IW'(count_q);

    always_comb begin
        count_d = count_q;
        if (push) begin
            count_d = count_q + CW'(1);
        end else if (pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Contents are never observable after reset, so storage is left unreset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign top_data = mem_q[rd_idx];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/program_register_stack.sv
// Processor state register (PC/MAR style) with byte-enabled load, increment,
// add, clear and a LIFO shadow stack for save/restore across nested traps.
module program_register_stack
    import program_register_pkg::*;
#(
    parameter int                WIDTH = 32,
    parameter logic [WIDTH-1:0]  INIT  = '0,
    parameter int unsigned       STEP  = 4,
    parameter int                DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OP_W-1:0]            op,
    input  logic [WIDTH-1:0]           in,
    input  logic [WIDTH/8-1:0]         byte_en,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int               NB     = WIDTH / 8;
    localparam int               CW     = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    op_t              op_e;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] top_data;
    logic             lifo_push;
    logic             lifo_pop;
    logic             lifo_full;
    logic             lifo_empty;
    logic [CW-1:0]    lifo_count;

    assign op_e = op_t'(op);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte_merge
            assign load_val[8*gi +: 8] = byte_en[gi] ? in[8*gi +: 8] : out_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        out_d     = out_q;
        err_d     = 1'b0;
        lifo_push = 1'b0;
        lifo_pop  = 1'b0;
        case (op_e)
            OP_HOLD:  out_d = out_q;
            OP_LOAD:  out_d = load_val;
            OP_INCR:  out_d = out_q + STEP_W;
            OP_ADD:   out_d = out_q + in;
            OP_PUSH: begin
                if (lifo_full) begin
                    err_d = 1'b1;
                end else begin
                    lifo_push = 1'b1;
                    out_d     = in;
                end
            end
            OP_POP: begin
                if (lifo_empty) begin
                    err_d = 1'b1;
                end else begin
                    lifo_pop = 1'b1;
                    out_d    = top_data;
                end
            end
            OP_CLEAR: out_d = INIT;
            default:  err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= INIT;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    // The current register value is what gets saved on a push.
    shadow_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lifo_push),
        .pop       (lifo_pop),
        .push_data (out_q),
        .top_data  (top_data),
        .count     (lifo_count),
        .full      (lifo_full),
        .empty     (lifo_empty)
    );

    assign out       = out_q;
    assign err       = err_q;
    assign depth_cnt = lifo_count;
    assign full      = lifo_full;
    assign empty     = lifo_empty;

endmodule
